// File: rtl/dbg_trigger_unit.sv
// Debug trigger (breakpoint) unit: tselect/tdata1/tdata2/tinfo CSRs plus
// per-trigger address comparators on the execute PC and the load/store
// address. Produces a registered one-cycle breakpoint pulse.
module dbg_trigger_unit #(
    parameter int NUM_TRIG = 2,
    parameter int XLEN     = 32
) (
    input  logic                cpu_clk,
    input  logic                cpu_rstn,
    input  logic                dbg_mode,
    input  logic [1:0]          priv,
    input  logic [11:0]         csr_addr,
    input  logic                csr_wr_en,
    input  logic [XLEN-1:0]     csr_wr_data,
    output logic [XLEN-1:0]     csr_rd_data,
    input  logic                exe_valid,
    input  logic [XLEN-1:0]     exe_pc,
    input  logic                mem_valid,
    input  logic                mem_is_store,
    input  logic [XLEN-1:0]     mem_addr,
    output logic                breakpoint,
    output logic [NUM_TRIG-1:0] trig_hit
);

    localparam int SEL_W = (NUM_TRIG > 1) ? $clog2(NUM_TRIG) : 1;

    localparam logic [11:0] ADDR_TSELECT = 12'h7A0;
    localparam logic [11:0] ADDR_TDATA1  = 12'h7A1;
    localparam logic [11:0] ADDR_TDATA2  = 12'h7A2;
    localparam logic [11:0] ADDR_TINFO   = 12'h7A4;

    // Match encodings: 0 equal, 2 unsigned >=, 3 unsigned <
    function automatic logic addr_cmp(input logic [3:0] match,
                                      input logic [XLEN-1:0] a,
                                      input logic [XLEN-1:0] b);
        case (match)
            4'd2:    addr_cmp = (a >= b);
            4'd3:    addr_cmp = (a < b);
            default: addr_cmp = (a == b);
        endcase
    endfunction

    // Unsupported match encodings collapse to "equal"
    function automatic logic [3:0] legal_match(input logic [3:0] m);
        legal_match = (m == 4'd2 || m == 4'd3) ? m : 4'd0;
    endfunction

    logic [SEL_W-1:0]    tselect_q, tselect_d;
    logic [NUM_TRIG-1:0] hit_q, hit_d;
    logic [NUM_TRIG-1:0] m_q, m_d;
    logic [NUM_TRIG-1:0] u_q, u_d;
    logic [NUM_TRIG-1:0] exe_q, exe_d;
    logic [NUM_TRIG-1:0] store_q, store_d;
    logic [NUM_TRIG-1:0] load_q, load_d;
    logic [3:0]          match_q  [NUM_TRIG];
    logic [3:0]          match_d  [NUM_TRIG];
    logic [XLEN-1:0]     tdata2_q [NUM_TRIG];
    logic [XLEN-1:0]     tdata2_d [NUM_TRIG];
    logic                breakpoint_q, breakpoint_d;
    logic [NUM_TRIG-1:0] fire;

    logic wr_tsel, wr_td1, wr_td2;

    // tselect is writable in any mode; tdata1/tdata2 only from debug mode
    assign wr_tsel = csr_wr_en && (csr_addr == ADDR_TSELECT) &&
                     (csr_wr_data < XLEN'(NUM_TRIG));
    assign wr_td1  = csr_wr_en && dbg_mode && (csr_addr == ADDR_TDATA1);
    assign wr_td2  = csr_wr_en && dbg_mode && (csr_addr == ADDR_TDATA2);

    generate
        for (genvar gi = 0; gi < NUM_TRIG; gi++) begin : g_trig
            logic en_priv, exe_hit, mem_hit;
            assign en_priv = ((priv == 2'b11) && m_q[gi]) ||
                             ((priv == 2'b00) && u_q[gi]);
            assign exe_hit = exe_valid && exe_q[gi] &&
                             addr_cmp(match_q[gi], exe_pc, tdata2_q[gi]);
            assign mem_hit = mem_valid &&
                             (mem_is_store ? store_q[gi] : load_q[gi]) &&
                             addr_cmp(match_q[gi], mem_addr, tdata2_q[gi]);
            // Suppressed in debug mode and while a pulse is already out,
            // so the controller never sees back-to-back pulses
            assign fire[gi] = en_priv && (exe_hit || mem_hit) &&
                              !dbg_mode && !breakpoint_q;
        end
    endgenerate

    // Next-state: sticky hits from fire, then CSR writes (write wins)
    always_comb begin
        tselect_d    = tselect_q;
        breakpoint_d = |fire;
        hit_d        = hit_q | fire;
        m_d          = m_q;
        u_d          = u_q;
        exe_d        = exe_q;
        store_d      = store_q;
        load_d       = load_q;
        match_d      = match_q;
        tdata2_d     = tdata2_q;
        if (wr_tsel) begin
            tselect_d = csr_wr_data[SEL_W-1:0];
        end
        for (int i = 0; i < NUM_TRIG; i++) begin
            if (tselect_q == SEL_W'(i)) begin
                if (wr_td1) begin
                    hit_d[i]   = csr_wr_data[20];
                    match_d[i] = legal_match(csr_wr_data[10:7]);
                    m_d[i]     = csr_wr_data[6];
                    u_d[i]     = csr_wr_data[4];
                    exe_d[i]   = csr_wr_data[2];
                    store_d[i] = csr_wr_data[1];
                    load_d[i]  = csr_wr_data[0];
                end
                if (wr_td2) begin
                    tdata2_d[i] = csr_wr_data;
                end
            end
        end
    end

    // State registers; reset drops any pending pulse and disables triggers
    always_ff @(posedge cpu_clk) begin
        if (!cpu_rstn) begin
            tselect_q    <= '0;
            hit_q        <= '0;
            m_q          <= '0;
            u_q          <= '0;
            exe_q        <= '0;
            store_q      <= '0;
            load_q       <= '0;
            breakpoint_q <= 1'b0;
            for (int i = 0; i < NUM_TRIG; i++) begin
                match_q[i]  <= '0;
                tdata2_q[i] <= '0;
            end
        end else begin
            tselect_q    <= tselect_d;
            hit_q        <= hit_d;
            m_q          <= m_d;
            u_q          <= u_d;
            exe_q        <= exe_d;
            store_q      <= store_d;
            load_q       <= load_d;
            breakpoint_q <= breakpoint_d;
            match_q      <= match_d;
            tdata2_q     <= tdata2_d;
        end
    end

    logic [31:0] tdata1_word;

    // tdata1 image of the selected trigger with its fixed fields
    always_comb begin
        tdata1_word = {4'h2, 1'b1, 6'd0, hit_q[tselect_q], 1'b0, 1'b0, 2'b00,
                       4'h1, 1'b0, match_q[tselect_q], m_q[tselect_q], 1'b0,
                       u_q[tselect_q], 1'b0, exe_q[tselect_q],
                       store_q[tselect_q], load_q[tselect_q]};
    end

    // Combinational CSR read mux; unowned addresses read zero
    always_comb begin
        csr_rd_data = '0;
        case (csr_addr)
            ADDR_TSELECT: csr_rd_data = XLEN'(tselect_q);
            ADDR_TDATA1:  csr_rd_data = XLEN'(tdata1_word);
            ADDR_TDATA2:  csr_rd_data = tdata2_q[tselect_q];
            ADDR_TINFO:   csr_rd_data = XLEN'(32'h4);
            default:      csr_rd_data = '0;
        endcase
    end

    assign breakpoint = breakpoint_q;
    assign trig_hit   = hit_q;

endmodule
